// File: rtl/excp_sequencer.sv
// rtl/excp_sequencer.sv - multicycle exception sequencer: EPC save, vector fetch, PC load
module excp_sequencer #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter logic [31:0] EPC_OFFSET  = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_opcode,
   input  logic        exc_overflow,
   input  logic        exc_divzero,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  flagExcpCtrl,
   output logic        mem_rd,
   output logic        epc_wr,
   output logic [31:0] epc_data,
   output logic        pc_wr,
   output logic [31:0] pc_next,
   output logic        busy,
   output logic        done,
   output logic [1:0]  cause
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SAVE_EPC = 3'd1,
      S_MEM_REQ  = 3'd2,
      S_MEM_WAIT = 3'd3,
      S_LOAD_PC  = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   localparam logic [2:0] LAT = 3'(MEM_LATENCY);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic [1:0]  flag_q, flag_d;
   logic        mem_rd_q, mem_rd_d;
   logic        epc_wr_q, epc_wr_d;
   logic        pc_wr_q, pc_wr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Only the low byte of the vector table entry is a handler address.
   logic        unused_rdata_hi;
   assign unused_rdata_hi = ^mem_rdata[31:8];

   // Next-state, capture and registered-output decode; outputs follow the state being entered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      epc_d   = epc_q;
      case (state_q)
         S_IDLE: begin
            if (exc_opcode || exc_overflow || exc_divzero) begin
               if (exc_opcode)        cause_d = 2'b01;
               else if (exc_overflow) cause_d = 2'b10;
               else                   cause_d = 2'b11;
               // EPC is formed at capture time; wraps modulo 2^32.
               epc_d   = pc_in - EPC_OFFSET;
               state_d = S_SAVE_EPC;
            end
         end
         S_SAVE_EPC: state_d = S_MEM_REQ;
         S_MEM_REQ: begin
            cnt_d   = LAT;
            state_d = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) state_d = S_LOAD_PC;
         end
         S_LOAD_PC: state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      epc_wr_d = (state_d == S_SAVE_EPC);
      mem_rd_d = (state_d == S_MEM_REQ);
      pc_wr_d  = (state_d == S_LOAD_PC);
      done_d   = (state_d == S_DONE);
      busy_d   = (state_d != S_IDLE);
      flag_d   = 2'b00;
      if ((state_d == S_SAVE_EPC) || (state_d == S_MEM_REQ) ||
          (state_d == S_MEM_WAIT) || (state_d == S_LOAD_PC))
         flag_d = cause_d;
   end

   // Sequencer state and registered outputs; reset aborts any sequence in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         cause_q  <= 2'b00;
         epc_q    <= 32'd0;
         flag_q   <= 2'b00;
         mem_rd_q <= 1'b0;
         epc_wr_q <= 1'b0;
         pc_wr_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
         flag_q   <= flag_d;
         mem_rd_q <= mem_rd_d;
         epc_wr_q <= epc_wr_d;
         pc_wr_q  <= pc_wr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign flagExcpCtrl = flag_q;
   assign mem_rd       = mem_rd_q;
   assign epc_wr       = epc_wr_q;
   assign epc_data     = epc_q;
   assign pc_wr        = pc_wr_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign cause        = cause_q;
   // Handler byte passes straight through while the PC write is asserted.
   assign pc_next      = pc_wr_q ? {24'b0, mem_rdata[7:0]} : 32'd0;

endmodule

// File: tb/tb_excp_sequencer.sv
// tb/tb_excp_sequencer.sv - randomized self-checking bench for excp_sequencer
module tb_excp_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  exc_op, exc_ov, exc_dz;
   logic [31:0] pc_in [2];
   logic [31:0] mem_rdata [2];
   logic [1:0]  flag [2];
   logic [1:0]  cause [2];
   logic [31:0] epc_data [2];
   logic [31:0] pc_next [2];
   logic [1:0]  mem_rd, epc_wr, pc_wr, busy, done;

   int checks_total  = 0;
   int checks_passed = 0;

   // Reference model: cycles elapsed since detection (0 = idle).
   int          phase [2] = '{0, 0};
   logic [1:0]  mcause [2] = '{2'b00, 2'b00};
   logic [31:0] mepc [2] = '{32'd0, 32'd0};

   always #5 clk = ~clk;

   excp_sequencer dut0 (
      .clk(clk), .reset(reset),
      .exc_opcode(exc_op[0]), .exc_overflow(exc_ov[0]), .exc_divzero(exc_dz[0]),
      .pc_in(pc_in[0]), .mem_rdata(mem_rdata[0]),
      .flagExcpCtrl(flag[0]), .mem_rd(mem_rd[0]), .epc_wr(epc_wr[0]),
      .epc_data(epc_data[0]), .pc_wr(pc_wr[0]), .pc_next(pc_next[0]),
      .busy(busy[0]), .done(done[0]), .cause(cause[0])
   );

   excp_sequencer #(.MEM_LATENCY(4)) dut1 (
      .clk(clk), .reset(reset),
      .exc_opcode(exc_op[1]), .exc_overflow(exc_ov[1]), .exc_divzero(exc_dz[1]),
      .pc_in(pc_in[1]), .mem_rdata(mem_rdata[1]),
      .flagExcpCtrl(flag[1]), .mem_rd(mem_rd[1]), .epc_wr(epc_wr[1]),
      .epc_data(epc_data[1]), .pc_wr(pc_wr[1]), .pc_next(pc_next[1]),
      .busy(busy[1]), .done(done[1]), .cause(cause[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            phase[i]  = 0;
            mcause[i] = 2'b00;
         end else if (phase[i] == 0) begin
            if (exc_op[i] | exc_ov[i] | exc_dz[i]) begin
               mcause[i] = exc_op[i] ? 2'b01 : (exc_ov[i] ? 2'b10 : 2'b11);
               mepc[i]   = pc_in[i] - 32'd4;
               phase[i]  = 1;
            end
         end else if (phase[i] == 4 + lat_of(i)) begin
            phase[i] = 0;
         end else begin
            phase[i] = phase[i] + 1;
         end
      end
   endtask

   task automatic compare();
      for (int i = 0; i < 2; i++) begin
         int L;
         int p;
         logic [1:0] ef;
         L  = lat_of(i);
         p  = phase[i];
         ef = (p >= 1 && p <= 3 + L) ? mcause[i] : 2'b00;
         chk($sformatf("d%0d_busy", i),   {31'b0, busy[i]},   {31'b0, p != 0});
         chk($sformatf("d%0d_epc_wr", i), {31'b0, epc_wr[i]}, {31'b0, p == 1});
         chk($sformatf("d%0d_mem_rd", i), {31'b0, mem_rd[i]}, {31'b0, p == 2});
         chk($sformatf("d%0d_pc_wr", i),  {31'b0, pc_wr[i]},  {31'b0, p == 3 + L});
         chk($sformatf("d%0d_done", i),   {31'b0, done[i]},   {31'b0, p == 4 + L});
         chk($sformatf("d%0d_flag", i),   {30'b0, flag[i]},   {30'b0, ef});
         chk($sformatf("d%0d_cause", i),  {30'b0, cause[i]},  {30'b0, mcause[i]});
         if (p == 1) chk($sformatf("d%0d_epc_data", i), epc_data[i], mepc[i]);
         if (p == 3 + L) chk($sformatf("d%0d_pc_next", i), pc_next[i], {24'b0, mem_rdata[i][7:0]});
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic zero_check(input string pfx);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_d%0d_flag", pfx, i),     {30'b0, flag[i]},  32'd0);
         chk($sformatf("%s_d%0d_cause", pfx, i),    {30'b0, cause[i]}, 32'd0);
         chk($sformatf("%s_d%0d_strobes", pfx, i),
             {27'b0, mem_rd[i], epc_wr[i], pc_wr[i], busy[i], done[i]}, 32'd0);
         chk($sformatf("%s_d%0d_epc_data", pfx, i), epc_data[i], 32'd0);
         chk($sformatf("%s_d%0d_pc_next", pfx, i),  pc_next[i],  32'd0);
      end
   endtask

   task automatic clear_reqs();
      exc_op = 2'b00;
      exc_ov = 2'b00;
      exc_dz = 2'b00;
   endtask

   initial begin
      int cnt;
      int k_memrd, k_pcwr, k_done;
      logic [31:0] seen_pc_next;

      // Reset held with every request high.
      reset = 1'b0;
      exc_op = 2'b11; exc_ov = 2'b11; exc_dz = 2'b11;
      for (int i = 0; i < 2; i++) begin
         pc_in[i]     = 32'h1234_5678;
         mem_rdata[i] = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      zero_check("rst_hold");
      repeat (3) cycle();
      clear_reqs();
      reset = 1'b1;
      repeat (3) cycle();
      zero_check("rst_release");

      // Overflow path at default latency.
      exc_ov[0] = 1'b1; pc_in[0] = 32'h40; mem_rdata[0] = 32'hFE;
      cycle();
      chk("ovf_epc_data", epc_data[0], 32'h3C);
      exc_ov[0] = 1'b0;
      repeat (7) cycle();
      chk("ovf_cause_after", {30'b0, cause[0]}, 32'd2);

      // Priority: all three, then overflow + divzero.
      exc_op[0] = 1'b1; exc_ov[0] = 1'b1; exc_dz[0] = 1'b1;
      cycle();
      chk("prio_all_flag", {30'b0, flag[0]}, 32'd1);
      clear_reqs();
      repeat (7) cycle();
      chk("prio_all_cause", {30'b0, cause[0]}, 32'd1);
      exc_ov[0] = 1'b1; exc_dz[0] = 1'b1;
      cycle();
      clear_reqs();
      repeat (7) cycle();
      chk("prio_ov_dz_cause", {30'b0, cause[0]}, 32'd2);

      // PC wrap-around and a request ignored while busy.
      exc_dz[0] = 1'b1; pc_in[0] = 32'd0;
      cycle();
      chk("wrap_epc_data", epc_data[0], 32'hFFFF_FFFC);
      exc_dz[0] = 1'b0;
      cnt = 0;
      cycle();
      cycle();
      exc_op[0] = 1'b1;
      cycle();
      exc_op[0] = 1'b0;
      repeat (8) begin
         cycle();
         cnt += int'(done[0]);
      end
      chk("busy_ignore_done_count", cnt, 1);
      chk("busy_ignore_cause", {30'b0, cause[0]}, 32'd3);

      // Latency parameter 4.
      exc_op[1] = 1'b1; pc_in[1] = 32'h100; mem_rdata[1] = 32'hABCD_12FD;
      cycle();
      exc_op[1] = 1'b0;
      k_memrd = 0; k_pcwr = 0; k_done = 0; seen_pc_next = 32'd0;
      for (int k = 2; k <= 10; k++) begin
         cycle();
         if (mem_rd[1]) k_memrd = k;
         if (pc_wr[1]) begin
            k_pcwr = k;
            seen_pc_next = pc_next[1];
         end
         if (done[1]) k_done = k;
      end
      chk("lat4_mem_rd_cycle", k_memrd, 2);
      chk("lat4_pc_wr_cycle", k_pcwr, 7);
      chk("lat4_done_cycle", k_done, 8);
      chk("lat4_pc_next", seen_pc_next, 32'hFD);

      // Reset asserted during MEM_WAIT.
      exc_ov[0] = 1'b1; pc_in[0] = 32'h200;
      cycle();
      exc_ov[0] = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
      #1;
      zero_check("rst_mid");
      cycle();
      reset = 1'b1;
      cnt = 0;
      repeat (10) begin
         cycle();
         cnt += int'(pc_wr[0]) + int'(done[0]);
      end
      chk("rst_mid_no_pulses", cnt, 0);

      // Randomized traffic with occasional resets.
      repeat (4000) begin
         for (int i = 0; i < 2; i++) begin
            exc_op[i]    = ($urandom_range(0, 7) == 0);
            exc_ov[i]    = ($urandom_range(0, 7) == 0);
            exc_dz[i]    = ($urandom_range(0, 7) == 0);
            pc_in[i]     = $urandom;
            mem_rdata[i] = $urandom;
         end
         reset = ($urandom_range(0, 299) != 0);
         cycle();
      end
      reset = 1'b1;
      clear_reqs();
      repeat (10) cycle();

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
